uart_serial_rx: RTL and testbench

Standalone serial-line receiver that decodes frames emitted on a UART16550 `pad_stx_o` line and presents each received character on a valid/ready output with per-character error flags. It decodes the same frame formats as the 16550 line-control register and uses the same divisor semantics, with a bit period of 16 × divisor clocks. It sits on the serial side of the UART16550 as the receiving end of the transmitter. It serves as a synthesizable loopback/check receiver in simulation and as a lightweight RX-only UART in designs that need no Wishbone register file.

---
 rtl/uart_serial_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_serial_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial_rx.sv
// -----------------------------------------------------------------------------
// uart_serial_rx
//
// Standalone receiver for frames produced on a UART16550 serial output line.
// It decodes 5..8 data bits, optional (stick) parity and one stop bit. The bit
// period is 16 x div_i clocks. Each character is presented on a valid/ready
// output together with parity, framing and break flags. A sticky overrun flag
// records characters that were dropped because the consumer was not ready.
//
// Optional feature macro: UART_SERIAL_RX_MAJORITY_EN
//   defined   : each bit is the 2-of-3 vote of samples 6, 7 and 8
//   undefined : each bit is the single sample taken at count 7
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   en_i             receiver enable (low holds FSM idle, stops ticks)
//   div_i            baud divisor, 16550 DLM:DLL meaning, 0 disables
//   lcr_i[5:0]       frame format, 16550 LCR[5:0] meaning
//   rxd_i            asynchronous serial input, idle high
//   data_o           received character, bits above word length are 0
//   valid_o/ready_i  output handshake
//   pe_o, fe_o, bi_o parity error, framing error, break for data_o
//   oe_o, oe_clr_i   sticky overrun flag and its clear
// -----------------------------------------------------------------------------
module uart_serial_rx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [5:0]       lcr_i,
  input  logic             rxd_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             pe_o,
  output logic             fe_o,
  output logic             bi_o,
  output logic             oe_o,
  input  logic             oe_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_e;

  // Only the first stop bit is checked, so the stop-bit select is unused.
  logic unused_stop_sel;
  assign unused_stop_sel = lcr_i[2];

  // ---------------------------------------------------------------------------
  // Input synchronizer. Resets to the idle level so reset release is never
  // mistaken for a start bit.
  // ---------------------------------------------------------------------------
  logic sync1_q, rxs_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, making the two stages a real
  // shift chain rather than a single wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxs_q   <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator: 16 ticks per bit. The counter idles at 0 so the first
  // tick after enabling arrives immediately; a new divisor is picked up at
  // the next reload.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_run, tick;

  assign tick_run = en_i && (div_i != '0);
  assign tick     = tick_run && (tick_cnt_q == '0);

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!tick_run)  tick_cnt_d = '0;
    else if (tick)  tick_cnt_d = div_i - DIV_W'(1);
    else            tick_cnt_d = tick_cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Bit sampling
  // ---------------------------------------------------------------------------
  logic [3:0] samp_q, samp_d;
  logic       bit_val;
  logic       sample;

`ifdef UART_SERIAL_RX_MAJORITY_EN
  // The vote is decided at count 8, once the third sample is on rxs_q.
  localparam logic [3:0] SAMPLE_PT = 4'd8;
  logic s6_q, s7_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else if (tick) begin
      if (samp_q == 4'd6) s6_q <= rxs_q;
      if (samp_q == 4'd7) s7_q <= rxs_q;
    end
  end

  assign bit_val = (s6_q & s7_q) | (s6_q & rxs_q) | (s7_q & rxs_q);
`else
  localparam logic [3:0] SAMPLE_PT = 4'd7;
  assign bit_val = rxs_q;
`endif

  assign sample = tick && (samp_q == SAMPLE_PT);

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic       ones_q, ones_d;       // any 1 seen in data/parity (break test)
  logic [2:0] last_idx;
  logic       exp_par;
  logic       commit, commit_fe, commit_bi;

  assign last_idx = 3'd4 + {1'b0, lcr_i[1:0]};
  // Stick parity forces ~EPS; otherwise XOR of data, inverted for odd parity.
  // Unused high bits of shift_q are 0 and do not disturb the XOR.
  assign exp_par  = lcr_i[5] ? ~lcr_i[4] : ((^shift_q) ^ ~lcr_i[4]);

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    ones_d    = ones_q;
    commit    = 1'b0;
    commit_fe = 1'b0;
    commit_bi = 1'b0;

    if (tick) samp_d = samp_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        if (tick && !rxs_q) begin
          state_d   = S_START;
          samp_d    = '0;
          bit_idx_d = '0;
          shift_d   = '0;
          par_err_d = 1'b0;
          ones_d    = 1'b0;
        end
      end
      S_START: begin
        if (sample) state_d = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = bit_val;
          ones_d             = ones_q | bit_val;
          if (bit_idx_q == last_idx) state_d = lcr_i[3] ? S_PARITY : S_STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_err_d = (bit_val != exp_par);
          ones_d    = ones_q | bit_val;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          commit    = 1'b1;
          commit_fe = ~bit_val;
          commit_bi = ~ones_q & ~bit_val;
          state_d   = commit_bi ? S_BRK_WAIT : S_IDLE;
        end
      end
      S_BRK_WAIT: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping enable aborts the frame; ticks are already stopped so no
    // commit can happen in this cycle.
    if (!en_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      samp_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      ones_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      ones_q    <= ones_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. A commit is accepted when the slot is free or is being
  // emptied this cycle; otherwise it is dropped and flagged as overrun.
  // ---------------------------------------------------------------------------
  logic [7:0] data_q;
  logic       valid_q, pe_q, fe_q, bi_q, oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      if (commit && (!valid_q || ready_i)) begin
        data_q  <= shift_q;
        pe_q    <= par_err_q;
        fe_q    <= commit_fe;
        bi_q    <= commit_bi;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      if (commit && valid_q && !ready_i) oe_q <= 1'b1;
      else if (oe_clr_i)                 oe_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign pe_o    = pe_q;
  assign fe_o    = fe_q;
  assign bi_o    = bi_q;
  assign oe_o    = oe_q;

endmodule

// File: tb/tb_uart_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_serial_rx
//
// Directed bench for uart_serial_rx at div_i=2 (32 clocks per bit). The
// stimulus thread serialises frames and pushes the hand-computed character
// it expects into a queue; a monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_serial_rx;

  localparam int DIV = 2;
  localparam int BIT = 16 * DIV;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en_i     = 1'b1;
  logic [15:0] div_i    = 16'(DIV);
  logic [5:0]  lcr_i    = 6'h1B;
  logic        rxd_i    = 1'b1;
  logic        ready_i  = 1'b1;
  logic        oe_clr_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o, pe_o, fe_o, bi_o, oe_o;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       oe;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    checks   = 0;
  int    failures = 0;

  uart_serial_rx #(.DIV_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .div_i    (div_i),
    .lcr_i    (lcr_i),
    .rxd_i    (rxd_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .pe_o     (pe_o),
    .fe_o     (fe_o),
    .bi_o     (bi_o),
    .oe_o     (oe_o),
    .oe_clr_i (oe_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%04h required=%04h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per handshake; {data,pe,fe,bi,oe} packed.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_char", 16'({data_o, pe_o, fe_o, bi_o, oe_o}), 16'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("char", 16'({data_o, pe_o, fe_o, bi_o, oe_o}), 16'(mon_e));
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
    exp_q.push_back('{data: d, pe: pe, fe: fe, bi: bi, oe: 1'b0});
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start, nb data bits LSB first, optional parity, stop, one idle bit.
  // A bad stop bit is held low for 20 clocks only, covering the sample
  // point but releasing the line before a false start could be validated.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic par, input logic stop_ok);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < nb; i++) drive_bit(d[i], BIT);
    if (pen) drive_bit(par, BIT);
    if (stop_ok) drive_bit(1'b1, BIT);
    else begin
      drive_bit(1'b0, 20);
      drive_bit(1'b1, BIT - 20);
    end
    drive_bit(1'b1, BIT);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20 * BIT) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 16'(exp_q.size()), 16'h0);
    exp_q.delete();
  endtask

  // Restart the tick generator from a known phase.
  task automatic align_enable();
    @(posedge clk); #1 en_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 en_i = 1'b1;
  endtask

  task automatic pulse_oe_clr();
    oe_clr_i = 1'b1;
    @(posedge clk); #1 oe_clr_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  found;

    // ---- reset ----
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", 16'({data_o, valid_o, pe_o, fe_o, bi_o, oe_o}), 16'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("post_rst_idle", 16'({data_o, valid_o, pe_o, fe_o, bi_o, oe_o}), 16'h0);

    // ---- 8E1 two bytes, back to back ----
    push(8'h81, 1'b0, 1'b0, 1'b0); send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
    push(8'h42, 1'b0, 1'b0, 1'b0); send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
    drain("drain_8e1");

    // ---- parity error, then framing error ----
    push(8'h81, 1'b1, 1'b0, 1'b0); send_frame(8'h81, 8, 1'b1, 1'b1, 1'b1);
    push(8'h42, 1'b0, 1'b1, 1'b0); send_frame(8'h42, 8, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, BIT);
    drain("drain_pe_fe");

    // ---- break: 20 bit times low, single commit, then clean byte ----
    push(8'h00, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b0, 20 * BIT);
    drive_bit(1'b1, 2 * BIT);
    push(8'h42, 1'b0, 1'b0, 1'b0); send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
    drain("drain_break");

    // ---- overrun ----
    ready_i = 1'b0;
    push(8'h81, 1'b0, 1'b0, 1'b0); send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
    check("ovr_first",  16'({valid_o, data_o}), 16'h181);
    check("ovr_oe_low", 16'(oe_o), 16'h0);
    send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
    check("ovr_keep",   16'({valid_o, data_o}), 16'h181);
    check("ovr_oe_set", 16'(oe_o), 16'h1);
    pulse_oe_clr();
    check("ovr_oe_clr", 16'(oe_o), 16'h0);

    // Find the commit edge relative to a known tick phase (it shows up as
    // the edge that sets oe_o), then replay the frame with ready_i high
    // for exactly that edge.
    align_enable();
    k = 0;
    found = 1'b0;
    fork
      send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
      begin
        for (int i = 1; i <= 2000; i++) begin
          if (!found) begin
            @(posedge clk); #2;
            if (oe_o) begin
              k = i;
              found = 1'b1;
            end
          end
        end
      end
    join
    check("calib_commit_seen", 16'(found), 16'h1);
    pulse_oe_clr();
    if (k < 2) k = 2;

    align_enable();
    push(8'h42, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
      begin
        repeat (k - 1) @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
      end
    join
    check("coincide_no_oe", 16'(oe_o), 16'h0);
    check("coincide_load",  16'({valid_o, data_o}), 16'h142);
    ready_i = 1'b1;
    drain("drain_ovr");

    // ---- formats ----
    lcr_i = 6'h00;
    push(8'h1F, 1'b0, 1'b0, 1'b0); send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
    lcr_i = 6'h0A;
    push(8'h55, 1'b0, 1'b0, 1'b0); send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
    lcr_i = 6'h3B;
    push(8'h81, 1'b0, 1'b0, 1'b0); send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
    push(8'h81, 1'b1, 1'b0, 1'b0); send_frame(8'h81, 8, 1'b1, 1'b1, 1'b1);
    drain("drain_formats");

    // ---- asynchronous reset mid-frame ----
    lcr_i   = 6'h1B;
    ready_i = 1'b0;
    send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
    check("pre_rst_held", 16'({valid_o, data_o}), 16'h142);
    fork
      send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 16'({data_o, valid_o, pe_o, fe_o, bi_o, oe_o}), 16'h0);
      end
    join
    @(posedge clk); #1 rst_n = 1'b1;
    ready_i = 1'b1;
    repeat (4) @(posedge clk); #1;
    push(8'h42, 1'b0, 1'b0, 1'b0); send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1);
    drain("drain_after_rst");

    // ---- enable dropped mid-frame ----
    fork
      send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1 en_i = 1'b0;
      end
    join
    @(posedge clk); #1 en_i = 1'b1;
    repeat (BIT) @(posedge clk); #1;
    check("abort_no_commit", 16'(valid_o), 16'h0);
    check("abort_keep_data", 16'(data_o), 16'h42);
    push(8'h81, 1'b0, 1'b0, 1'b0); send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1);
    drain("drain_after_abort");

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
